alu_op_sequencer: RTL



---
 rtl/alu_op_sequencer_if.sv | 32 +++
 rtl/alu_op_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle for alu_op_sequencer.
//   master : requester/consumer side (drives in_valid, op, a, b, out_ready)
//   slave  : sequencer side (drives in_ready, out_valid, result, flags, busy)
// Signals:
//   in_valid/in_ready   request handshake, op[2:0], a[N-1:0], b[N-1:0]
//   out_valid/out_ready result handshake, result[N-1:0], flag_zero, flag_msb
//   busy                sequencer is in BUSY or DONE
interface alu_op_sequencer_if #(
   parameter int N = 4
);
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] result;
   logic         flag_zero;
   logic         flag_msb;
   logic         busy;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, flag_zero, flag_msb, busy
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, flag_zero, flag_msb, busy
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready wrapper around an N-bit logic/shift unit.
// Logic ops (AND/OR/XOR, reserved 110/111 = AND) finish in one BUSY cycle;
// SRL/SLL/ROR shift one position per BUSY cycle, amount = b[SW-1:0].
// The result is held in DONE with zero/MSB flags until out_ready.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    alu_op_sequencer_if slave modport (request, result, status)
module alu_op_sequencer #(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input logic              clk,
   input logic              rst_n,
   alu_op_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_SLL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b101;

   state_t        state, state_nxt;
   logic [2:0]    op_q, op_nxt;
   logic [N-1:0]  b_q, b_nxt;
   logic [N-1:0]  acc, acc_nxt;
   logic [SW-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         op_q  <= '0;
         b_q   <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         op_q  <= op_nxt;
         b_q   <= b_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      op_nxt    = op_q;
      b_nxt     = b_q;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               op_nxt    = bus.op;
               b_nxt     = bus.b;
               acc_nxt   = bus.a;
               cnt_nxt   = bus.b[SW-1:0];
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            case (op_q)
               OP_SRL, OP_SLL, OP_ROR: begin
                  // Remaining count of zero means acc already holds the answer.
                  if (cnt == '0) begin
                     state_nxt = DONE;
                  end else begin
                     cnt_nxt = cnt - 1'b1;
                     case (op_q)
                        OP_SRL:  acc_nxt = {1'b0, acc[N-1:1]};
                        OP_SLL:  acc_nxt = {acc[N-2:0], 1'b0};
                        default: acc_nxt = {acc[0], acc[N-1:1]};
                     endcase
                  end
               end
               OP_OR: begin
                  acc_nxt   = acc | b_q;
                  state_nxt = DONE;
               end
               OP_XOR: begin
                  acc_nxt   = acc ^ b_q;
                  state_nxt = DONE;
               end
               default: begin
                  // OP_AND and the reserved encodings 110/111
                  acc_nxt   = acc & b_q;
                  state_nxt = DONE;
               end
            endcase
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // acc only changes in BUSY/IDLE-accept, so result and flags are stable in DONE.
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.result    = acc;
   assign bus.flag_zero = (acc == '0);
   assign bus.flag_msb  = acc[N-1];

endmodule
